// File: rtl/writeback_stage_if.sv
// Shared types and the bundle/commit interface between the memory stage and the writeback stage.
// The type package sits ahead of the interface because both the interface and the stage use it.
package writeback_stage_pkg;

    typedef enum logic [2:0] {
        EXCEPTION_NONE       = 3'd0,
        EXCEPTION_OVERFLOW   = 3'd1,
        EXCEPTION_ILLEGAL    = 3'd2,
        EXCEPTION_ADDR_LOAD  = 3'd3,
        EXCEPTION_ADDR_STORE = 3'd4
    } exception_t;

    typedef struct packed {
        logic reg_write;
        logic syscall;
    } wb_ctrl_t;

    typedef struct packed {
        logic        valid0;
        logic [31:0] instr_id0;
        logic [31:0] pc0;
        wb_ctrl_t    ctrl0;
        logic [4:0]  reg_write_addr0;
        logic [31:0] reg_write_data0;
        exception_t  exception0;
        logic        valid1;
        logic [31:0] instr_id1;
        logic [31:0] pc1;
        wb_ctrl_t    ctrl1;
        logic [4:0]  reg_write_addr1;
        logic [31:0] reg_write_data1;
        exception_t  exception1;
    } MEM_WB_Register;

endpackage

interface writeback_stage_if
    import writeback_stage_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    MEM_WB_Register   mem_wb_reg;
    logic             exc_ack;
    logic             rf_we0;
    logic [4:0]       rf_waddr0;
    logic [31:0]      rf_wdata0;
    logic             rf_we1;
    logic [4:0]       rf_waddr1;
    logic [31:0]      rf_wdata1;
    logic             exc_flush;
    logic [31:0]      exc_epc;
    exception_t       exc_cause;
    logic             halted;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        output mem_wb_reg, exc_ack,
        input  rf_we0, rf_waddr0, rf_wdata0, rf_we1, rf_waddr1, rf_wdata1,
        input  exc_flush, exc_epc, exc_cause, halted, retired_cnt
    );

    modport slave (
        input  mem_wb_reg, exc_ack,
        output rf_we0, rf_waddr0, rf_wdata0, rf_we1, rf_waddr1, rf_wdata1,
        output exc_flush, exc_epc, exc_cause, halted, retired_cnt
    );

endinterface

// File: rtl/writeback_stage.sv
// Dual-issue writeback: in-order retire of slot 0/1 with precise exceptions, EPC/cause capture and SYSCALL halt.
// Optional WB_COMMIT_TRACE_EN adds a commit trace printout and registered trace_valid/trace_id0/trace_id1 outputs.
//
// state | meaning
// RUN   | commits allowed; exceptions and SYSCALL are detected here
// EXC   | exception latched, flush issued; waiting for exc_ack
// HALT  | SYSCALL retired; core stopped until reset
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int ID_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
`ifdef WB_COMMIT_TRACE_EN
    output logic [1:0]       trace_valid,
    output logic [ID_W-1:0]  trace_id0,
    output logic [ID_W-1:0]  trace_id1,
`endif
    writeback_stage_if.slave wb
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        EXC  = 2'd1,
        HALT = 2'd2
    } wb_state_t;

    wb_state_t        state_q;
    wb_state_t        state_d;

    logic             in_run;
    logic             exc0_pending;
    logic             exc1_pending;
    logic             commit0;
    logic             commit1;
    logic             take_exc0;
    logic             take_exc1;
    logic             take_exc;
    logic             take_halt;
    logic             we0_raw;
    logic             we1_raw;
    logic             same_dst;
    logic [31:0]      exc_pc_sel;
    exception_t       exc_cause_sel;
    logic [CNT_W-1:0] retire_inc;

    logic             exc_flush_q;
    logic [31:0]      exc_epc_q;
    exception_t       exc_cause_q;
    logic             halted_q;
    logic [CNT_W-1:0] retired_cnt_q;

    // Commit and exception qualification for the current bundle.
    always_comb begin
        in_run       = (state_q == RUN);
        exc0_pending = wb.mem_wb_reg.valid0 && (wb.mem_wb_reg.exception0 != EXCEPTION_NONE);
        exc1_pending = wb.mem_wb_reg.valid1 && (wb.mem_wb_reg.exception1 != EXCEPTION_NONE);

        commit0   = in_run && wb.mem_wb_reg.valid0 && !exc0_pending;
        // A committed SYSCALL in slot 0 stops the younger slot as well.
        commit1   = commit0 && !wb.mem_wb_reg.ctrl0.syscall
                    && wb.mem_wb_reg.valid1 && !exc1_pending;

        take_exc0 = in_run && exc0_pending;
        take_exc1 = commit0 && !wb.mem_wb_reg.ctrl0.syscall && exc1_pending;
        take_exc  = take_exc0 || take_exc1;
        take_halt = (commit0 && wb.mem_wb_reg.ctrl0.syscall)
                    || (commit1 && wb.mem_wb_reg.ctrl1.syscall);

        exc_pc_sel    = 32'd0;
        exc_cause_sel = EXCEPTION_NONE;
        if (take_exc0) begin
            exc_pc_sel    = wb.mem_wb_reg.pc0;
            exc_cause_sel = wb.mem_wb_reg.exception0;
        end else if (take_exc1) begin
            exc_pc_sel    = wb.mem_wb_reg.pc1;
            exc_cause_sel = wb.mem_wb_reg.exception1;
        end

        retire_inc = {{(CNT_W-1){1'b0}}, commit0} + {{(CNT_W-1){1'b0}}, commit1};
    end

    // Register-file ports; when both slots hit the same register the younger slot wins.
    always_comb begin
        we0_raw  = commit0 && wb.mem_wb_reg.ctrl0.reg_write && (wb.mem_wb_reg.reg_write_addr0 != 5'd0);
        we1_raw  = commit1 && wb.mem_wb_reg.ctrl1.reg_write && (wb.mem_wb_reg.reg_write_addr1 != 5'd0);
        same_dst = (wb.mem_wb_reg.reg_write_addr0 == wb.mem_wb_reg.reg_write_addr1);

        wb.rf_we0    = rst && we0_raw && !(we1_raw && same_dst);
        wb.rf_we1    = rst && we1_raw;
        wb.rf_waddr0 = wb.mem_wb_reg.reg_write_addr0;
        wb.rf_wdata0 = wb.mem_wb_reg.reg_write_data0;
        wb.rf_waddr1 = wb.mem_wb_reg.reg_write_addr1;
        wb.rf_wdata1 = wb.mem_wb_reg.reg_write_data1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (take_exc) begin
                    state_d = EXC;
                end else if (take_halt) begin
                    state_d = HALT;
                end
            end
            EXC: begin
                if (wb.exc_ack) begin
                    state_d = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Architectural retire/exception state; EPC and cause hold until the next exception or reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_flush_q   <= 1'b0;
            exc_epc_q     <= 32'd0;
            exc_cause_q   <= EXCEPTION_NONE;
            halted_q      <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            exc_flush_q   <= take_exc;
            if (take_exc) begin
                exc_epc_q   <= exc_pc_sel;
                exc_cause_q <= exc_cause_sel;
            end
            if (take_halt) begin
                halted_q <= 1'b1;
            end
            retired_cnt_q <= retired_cnt_q + retire_inc;
        end
    end

    assign wb.exc_flush   = exc_flush_q;
    assign wb.exc_epc     = exc_epc_q;
    assign wb.exc_cause   = exc_cause_q;
    assign wb.halted      = halted_q;
    assign wb.retired_cnt = retired_cnt_q;

`ifdef WB_COMMIT_TRACE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trace_valid <= 2'b00;
            trace_id0   <= '0;
            trace_id1   <= '0;
        end else begin
            trace_valid <= {commit1, commit0};
            trace_id0   <= commit0 ? ID_W'(wb.mem_wb_reg.instr_id0) : '0;
            trace_id1   <= commit1 ? ID_W'(wb.mem_wb_reg.instr_id1) : '0;
        end
    end

    // Simulation-only commit log, slot 0 printed before slot 1.
    always @(posedge clk) begin
        if (rst && commit0) begin
            if (wb.rf_we0) begin
                $display("wb commit s0 id=%0h pc=%08h r%0d=%08h", wb.mem_wb_reg.instr_id0,
                         wb.mem_wb_reg.pc0, wb.mem_wb_reg.reg_write_addr0, wb.mem_wb_reg.reg_write_data0);
            end else begin
                $display("wb commit s0 id=%0h pc=%08h", wb.mem_wb_reg.instr_id0, wb.mem_wb_reg.pc0);
            end
        end
        if (rst && commit1) begin
            if (wb.rf_we1) begin
                $display("wb commit s1 id=%0h pc=%08h r%0d=%08h", wb.mem_wb_reg.instr_id1,
                         wb.mem_wb_reg.pc1, wb.mem_wb_reg.reg_write_addr1, wb.mem_wb_reg.reg_write_data1);
            end else begin
                $display("wb commit s1 id=%0h pc=%08h", wb.mem_wb_reg.instr_id1, wb.mem_wb_reg.pc1);
            end
        end
    end
`else
    // Instruction IDs only feed the trace; fold them away when it is not built.
    logic unused_instr_id;
    assign unused_instr_id = ^{ID_W'(wb.mem_wb_reg.instr_id0), ID_W'(wb.mem_wb_reg.instr_id1)};
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed-vector bench for writeback_stage: the driver queues hand-computed expectations per cycle,
// a monitor on the falling edge pops and compares them against the DUT outputs.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    typedef struct {
        string       name;
        logic        we0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        we1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        flush;
        logic [31:0] epc;
        exception_t  cause;
        logic        halted;
        logic [31:0] cnt;
    } exp_t;

    localparam exception_t N  = EXCEPTION_NONE;
    localparam exception_t OV = EXCEPTION_OVERFLOW;
    localparam exception_t IL = EXCEPTION_ILLEGAL;
    localparam exception_t AL = EXCEPTION_ADDR_LOAD;
    localparam exception_t AS = EXCEPTION_ADDR_STORE;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    writeback_stage_if #(.CNT_W(32)) wb_if ();

`ifdef WB_COMMIT_TRACE_EN
    logic [1:0]  trace_valid;
    logic [31:0] trace_id0;
    logic [31:0] trace_id1;
    writeback_stage #(.CNT_W(32), .ID_W(32)) dut (
        .clk(clk), .rst(rst),
        .trace_valid(trace_valid), .trace_id0(trace_id0), .trace_id1(trace_id1),
        .wb(wb_if)
    );
`else
    writeback_stage #(.CNT_W(32), .ID_W(32)) dut (
        .clk(clk), .rst(rst), .wb(wb_if)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic MEM_WB_Register mk(
        input logic v0, input logic [31:0] pc0, input logic rw0, input logic [4:0] a0,
        input logic [31:0] d0, input exception_t e0, input logic s0,
        input logic v1, input logic [31:0] pc1, input logic rw1, input logic [4:0] a1,
        input logic [31:0] d1, input exception_t e1, input logic s1);
        MEM_WB_Register b;
        b.valid0 = v0; b.instr_id0 = pc0; b.pc0 = pc0;
        b.ctrl0.reg_write = rw0; b.ctrl0.syscall = s0;
        b.reg_write_addr0 = a0; b.reg_write_data0 = d0; b.exception0 = e0;
        b.valid1 = v1; b.instr_id1 = pc1; b.pc1 = pc1;
        b.ctrl1.reg_write = rw1; b.ctrl1.syscall = s1;
        b.reg_write_addr1 = a1; b.reg_write_data1 = d1; b.exception1 = e1;
        return b;
    endfunction

    function automatic exp_t ex(
        input string name, input logic we0, input logic [4:0] a0, input logic [31:0] d0,
        input logic we1, input logic [4:0] a1, input logic [31:0] d1, input logic flush,
        input logic [31:0] epc, input exception_t cause, input logic halted, input logic [31:0] cnt);
        exp_t e;
        e.name = name; e.we0 = we0; e.a0 = a0; e.d0 = d0; e.we1 = we1; e.a1 = a1; e.d1 = d1;
        e.flush = flush; e.epc = epc; e.cause = cause; e.halted = halted; e.cnt = cnt;
        return e;
    endfunction

    task automatic step(input logic r, input MEM_WB_Register b, input logic ack, input exp_t e);
        @(posedge clk);
        #1;
        rst = r;
        wb_if.mem_wb_reg = b;
        wb_if.exc_ack = ack;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the queued expectation for this cycle away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic bad;
            e = exp_q.pop_front();
            bad = (wb_if.rf_we0 !== e.we0) || (wb_if.rf_we1 !== e.we1)
                  || (e.we0 && ((wb_if.rf_waddr0 !== e.a0) || (wb_if.rf_wdata0 !== e.d0)))
                  || (e.we1 && ((wb_if.rf_waddr1 !== e.a1) || (wb_if.rf_wdata1 !== e.d1)))
                  || (wb_if.exc_flush !== e.flush) || (wb_if.exc_epc !== e.epc)
                  || (wb_if.exc_cause !== e.cause) || (wb_if.halted !== e.halted)
                  || (wb_if.retired_cnt !== e.cnt);
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL %s: got we0=%b a0=%0d d0=%h we1=%b a1=%0d d1=%h flush=%b epc=%h cause=%0d halted=%b cnt=%0d | want we0=%b a0=%0d d0=%h we1=%b a1=%0d d1=%h flush=%b epc=%h cause=%0d halted=%b cnt=%0d",
                         e.name, wb_if.rf_we0, wb_if.rf_waddr0, wb_if.rf_wdata0, wb_if.rf_we1,
                         wb_if.rf_waddr1, wb_if.rf_wdata1, wb_if.exc_flush, wb_if.exc_epc,
                         wb_if.exc_cause, wb_if.halted, wb_if.retired_cnt,
                         e.we0, e.a0, e.d0, e.we1, e.a1, e.d1, e.flush, e.epc, e.cause, e.halted, e.cnt);
            end
        end
    end

    initial begin
        MEM_WB_Register idle;
        MEM_WB_Register wr;
        int budget;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        idle = mk(0, 0, 0, 0, 0, N, 0, 0, 0, 0, 0, 0, N, 0);
        wr   = mk(1, 32'h4100, 1, 9, 32'h9, N, 0, 1, 32'h4104, 1, 10, 32'hA, N, 0);
        wb_if.mem_wb_reg = idle;
        wb_if.exc_ack    = 1'b0;

        step(0, mk(1, 32'h1000, 1, 3, 32'h11, N, 0, 1, 32'h1004, 1, 4, 32'h22, N, 0), 0,
             ex("reset", 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0));
        step(1, mk(1, 32'h1000, 1, 3, 32'h11, N, 0, 1, 32'h1004, 1, 4, 32'h22, N, 0), 0,
             ex("alu_pair", 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, N, 0, 0));
        step(1, mk(1, 32'h1008, 1, 5, 32'hA, N, 0, 1, 32'h100C, 1, 5, 32'hB, N, 0), 0,
             ex("same_addr", 0, 0, 0, 1, 5, 32'hB, 0, 0, N, 0, 2));
        step(1, mk(1, 32'h1010, 1, 0, 32'h55, N, 0, 1, 32'h1014, 0, 6, 32'h66, N, 0), 0,
             ex("zero_dst", 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 4));
        step(1, mk(1, 32'h3000, 1, 7, 32'h77, OV, 0, 1, 32'h3004, 1, 7, 32'h78, N, 0), 0,
             ex("slot0_exc", 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 6));
        step(1, mk(1, 32'h4000, 1, 7, 32'h1, IL, 0, 1, 32'h4004, 1, 8, 32'h2, N, 0), 0,
             ex("exc_flush", 0, 0, 0, 0, 0, 0, 1, 32'h3000, OV, 0, 6));
        step(1, wr, 0, ex("exc_hold", 0, 0, 0, 0, 0, 0, 0, 32'h3000, OV, 0, 6));
        step(1, wr, 1, ex("exc_ack_cycle", 0, 0, 0, 0, 0, 0, 0, 32'h3000, OV, 0, 6));
        step(1, mk(1, 32'h3000, 1, 2, 32'h7, N, 0, 1, 32'h3004, 1, 3, 32'h3, IL, 0), 0,
             ex("slot1_exc", 1, 2, 32'h7, 0, 0, 0, 0, 32'h3000, OV, 0, 6));
        step(1, idle, 1, ex("exc1_flush_ack", 0, 0, 0, 0, 0, 0, 1, 32'h3004, IL, 0, 7));
        step(1, mk(1, 32'h3100, 1, 8, 32'h80, N, 0, 0, 0, 0, 0, 0, N, 0), 0,
             ex("fast_ack_run", 1, 8, 32'h80, 0, 0, 0, 0, 32'h3004, IL, 0, 7));
        step(1, mk(1, 32'h3200, 1, 9, 32'h99, N, 1, 1, 32'h3204, 1, 10, 32'h1010, N, 0), 1,
             ex("syscall", 1, 9, 32'h99, 0, 0, 0, 0, 32'h3004, IL, 0, 8));
        step(1, wr, 0, ex("halted", 0, 0, 0, 0, 0, 0, 0, 32'h3004, IL, 1, 9));
        step(1, wr, 1, ex("halted_ack", 0, 0, 0, 0, 0, 0, 0, 32'h3004, IL, 1, 9));
        step(1, mk(1, 32'h3300, 1, 1, 32'h1, AS, 0, 0, 0, 0, 0, 0, N, 0), 0,
             ex("halted_exc", 0, 0, 0, 0, 0, 0, 0, 32'h3004, IL, 1, 9));
        step(0, wr, 0, ex("reset_halt", 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0));
        step(1, mk(1, 32'h4FFC, 1, 11, 32'h1, N, 0, 1, 32'h5000, 1, 12, 32'h2, AL, 0), 0,
             ex("post_reset", 1, 11, 32'h1, 0, 0, 0, 0, 0, N, 0, 0));
        step(1, idle, 0, ex("exc_flush2", 0, 0, 0, 0, 0, 0, 1, 32'h5000, AL, 0, 1));
        step(0, wr, 0, ex("reset_exc", 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0));
        step(1, mk(1, 32'h6000, 1, 12, 32'hC, N, 0, 1, 32'h6004, 1, 13, 32'hD, N, 0), 0,
             ex("run_after_reset", 1, 12, 32'hC, 1, 13, 32'hD, 0, 0, N, 0, 0));
        step(1, idle, 0, ex("final_cnt", 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 2));

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
